// File: rtl/riscv_core_hazard_pkg.sv
// Shared constants for the RV64 hazard controller.
// Stage/flush bit positions and the forward-select width helper.
package riscv_core_hazard_pkg;

  localparam int unsigned ST_IF  = 0;
  localparam int unsigned ST_ID  = 1;
  localparam int unsigned ST_EX  = 2;
  localparam int unsigned ST_MEM = 3;
  localparam int unsigned ST_WB  = 4;
  localparam int unsigned NUM_ST = 5;

  localparam int unsigned FL_ID  = 0;
  localparam int unsigned FL_EX  = 1;
  localparam int unsigned FL_MEM = 2;
  localparam int unsigned FL_WB  = 3;
  localparam int unsigned NUM_FL = 4;

  function automatic int unsigned sel_w(
    input int unsigned n
  );
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/riscv_core_hazard_scoreboard.sv
// Pending-writeback scoreboard for long-latency results.
// Tracks busy registers, outstanding count and RAW/WAW/full stalls.
module riscv_core_hazard_scoreboard
  import riscv_core_hazard_pkg::*;
#(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned MAX_PEND = 4,
  parameter int unsigned CNT_W    = $clog2(MAX_PEND + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [REG_W-1:0] rs1_i,
  input  logic [REG_W-1:0] rs2_i,
  input  logic [REG_W-1:0] rd_i,
  input  logic             issue_i,
  input  logic             stall_id_i,
  input  logic             done_i,
  input  logic [REG_W-1:0] done_rd_i,
  output logic             sb_stall_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int unsigned NUM_REGS = 2 ** REG_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_PEND);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                acc;
  logic                done_ok;
  logic                raw, waw, full;

  assign acc     = issue_i & ~stall_id_i
                 & (rd_i != '0);
  assign done_ok = done_i & pend_q[done_rd_i];

  assign raw  = pend_q[rs1_i] | pend_q[rs2_i];
  assign waw  = issue_i & pend_q[rd_i];
  assign full = issue_i & (cnt_q == FULL);

  assign sb_stall_o = raw | waw | full;
  assign cnt_o      = cnt_q;

  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (done_ok) pend_d[done_rd_i] = 1'b0;
    if (acc)     pend_d[rd_i]      = 1'b1;
    if (acc && !done_ok)      cnt_d = cnt_q + ONE;
    else if (done_ok && !acc) cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/riscv_core_hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use, scoreboard,
// stall/flush generation with flush holdover and stall watchdog.
module riscv_core_hazard_ctrl
  import riscv_core_hazard_pkg::*;
#(
  parameter int unsigned NUM_FWD  = 2,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned MAX_PEND = 4,
  parameter int unsigned WDOG_CYC = 1024,
  parameter int unsigned SEL_W    = sel_w(NUM_FWD),
  parameter int unsigned CNT_W    = $clog2(MAX_PEND + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [REG_W-1:0]         i_hazard_ctrl_rs1_id,
  input  logic [REG_W-1:0]         i_hazard_ctrl_rs2_id,
  input  logic [REG_W-1:0]         i_hazard_ctrl_rd_id,
  input  logic [REG_W-1:0]         i_hazard_ctrl_rs1_ex,
  input  logic [REG_W-1:0]         i_hazard_ctrl_rs2_ex,
  input  logic [REG_W-1:0]         i_hazard_ctrl_rd_ex,
  input  logic                     i_hazard_ctrl_load_ex,
  input  logic [NUM_FWD*REG_W-1:0] i_hazard_ctrl_fwd_rd,
  input  logic [NUM_FWD-1:0]       i_hazard_ctrl_fwd_we,
  input  logic                     i_hazard_ctrl_lat_issue,
  input  logic                     i_hazard_ctrl_lat_done,
  input  logic [REG_W-1:0]         i_hazard_ctrl_lat_done_rd,
  input  logic                     i_hazard_ctrl_pcsrc_ex,
  input  logic                     i_hazard_ctrl_icache_stall,
  input  logic                     i_hazard_ctrl_dcache_stall,
  input  logic [NUM_FL-1:0]        i_hazard_ctrl_csr_flush,
  output logic [SEL_W-1:0]         o_hazard_ctrl_fwda_ex,
  output logic [SEL_W-1:0]         o_hazard_ctrl_fwdb_ex,
  output logic [NUM_ST-1:0]        o_hazard_ctrl_stall,
  output logic [NUM_FL-1:0]        o_hazard_ctrl_flush,
  output logic [CNT_W-1:0]         o_hazard_ctrl_pend_cnt,
  output logic                     o_hazard_ctrl_timeout
);

  localparam int unsigned WD_W = $clog2(WDOG_CYC + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WDOG_CYC);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYC - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  logic [REG_W-1:0]  rs1_ex, rs2_ex, rd_ex;
  logic [SEL_W-1:0]  fwda, fwdb;
  logic              loaduse;
  logic              sb_stall;
  logic              dc, ic;
  logic [NUM_ST-1:0] stall;
  logic [NUM_FL-1:0] req, fl_stall;
  logic [NUM_FL-1:0] hold_q, hold_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              to_q, to_d;

  assign rs1_ex = i_hazard_ctrl_rs1_ex;
  assign rs2_ex = i_hazard_ctrl_rs2_ex;
  assign rd_ex  = i_hazard_ctrl_rd_ex;
  assign dc     = i_hazard_ctrl_dcache_stall;
  assign ic     = i_hazard_ctrl_icache_stall;

  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    fwda = '0;
    fwdb = '0;
    for (int k = NUM_FWD; k >= 1; k--) begin
      if (i_hazard_ctrl_fwd_we[k-1]) begin
        if (rs1_ex != '0 &&
            i_hazard_ctrl_fwd_rd[(k-1)*REG_W +: REG_W]
              == rs1_ex)
          fwda = SEL_W'(k);
        if (rs2_ex != '0 &&
            i_hazard_ctrl_fwd_rd[(k-1)*REG_W +: REG_W]
              == rs2_ex)
          fwdb = SEL_W'(k);
      end
    end
  end

  assign o_hazard_ctrl_fwda_ex = fwda;
  assign o_hazard_ctrl_fwdb_ex = fwdb;

  assign loaduse = i_hazard_ctrl_load_ex
                 & (rd_ex != '0)
                 & ((i_hazard_ctrl_rs1_id == rd_ex)
                  | (i_hazard_ctrl_rs2_id == rd_ex));

  riscv_core_hazard_scoreboard #(
    .REG_W    (REG_W),
    .MAX_PEND (MAX_PEND),
    .CNT_W    (CNT_W)
  ) u_sb (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .rs1_i      (i_hazard_ctrl_rs1_id),
    .rs2_i      (i_hazard_ctrl_rs2_id),
    .rd_i       (i_hazard_ctrl_rd_id),
    .issue_i    (i_hazard_ctrl_lat_issue),
    .stall_id_i (stall[ST_ID]),
    .done_i     (i_hazard_ctrl_lat_done),
    .done_rd_i  (i_hazard_ctrl_lat_done_rd),
    .sb_stall_o (sb_stall),
    .cnt_o      (o_hazard_ctrl_pend_cnt)
  );

  always_comb begin
    stall         = '0;
    stall[ST_IF]  = loaduse | sb_stall | ic | dc;
    stall[ST_ID]  = loaduse | sb_stall | dc;
    stall[ST_EX]  = dc;
    stall[ST_MEM] = dc;
    stall[ST_WB]  = 1'b0;
  end

  always_comb begin
    req         = '0;
    req[FL_ID]  = i_hazard_ctrl_pcsrc_ex
                | i_hazard_ctrl_csr_flush[FL_ID];
    req[FL_EX]  = i_hazard_ctrl_pcsrc_ex | loaduse
                | sb_stall
                | i_hazard_ctrl_csr_flush[FL_EX];
    req[FL_MEM] = i_hazard_ctrl_csr_flush[FL_MEM];
    req[FL_WB]  = i_hazard_ctrl_csr_flush[FL_WB];
  end

  // Flush bit s targets the stage at stall bit s+1.
  assign fl_stall = stall[NUM_ST-1:ST_ID];
  assign hold_d   = (req | hold_q) & fl_stall;

  assign o_hazard_ctrl_stall = stall;
  assign o_hazard_ctrl_flush = (req | hold_q) & ~fl_stall;

  always_comb begin
    wd_d = wd_q;
    to_d = to_q;
    if (stall[ST_IF]) begin
      if (wd_q != WD_MAX)  wd_d = wd_q + WD_ONE;
      if (wd_q == WD_LAST) to_d = 1'b1;
    end else begin
      wd_d = '0;
    end
  end

  assign o_hazard_ctrl_timeout = to_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_q <= '0;
      wd_q   <= '0;
      to_q   <= 1'b0;
    end else begin
      hold_q <= hold_d;
      wd_q   <= wd_d;
      to_q   <= to_d;
    end
  end

endmodule

// File: tb/tb_riscv_core_hazard_ctrl.sv
// Directed self-checking bench for riscv_core_hazard_ctrl.
// Linear stimulus with hand-computed expectations.
module tb_riscv_core_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs1_id, rs2_id, rd_id;
  logic [4:0] rs1_ex, rs2_ex, rd_ex;
  logic       load_ex;
  logic [9:0] fwd_rd;
  logic [1:0] fwd_we;
  logic       lat_issue, lat_done;
  logic [4:0] lat_done_rd;
  logic       pcsrc, icache, dcache;
  logic [3:0] csr;
  logic [1:0] fwda, fwdb;
  logic [4:0] stall;
  logic [3:0] flush;
  logic [2:0] pend_cnt;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  riscv_core_hazard_ctrl dut (
    .i_clk                      (clk),
    .i_rst_n                    (rst_n),
    .i_hazard_ctrl_rs1_id       (rs1_id),
    .i_hazard_ctrl_rs2_id       (rs2_id),
    .i_hazard_ctrl_rd_id        (rd_id),
    .i_hazard_ctrl_rs1_ex       (rs1_ex),
    .i_hazard_ctrl_rs2_ex       (rs2_ex),
    .i_hazard_ctrl_rd_ex        (rd_ex),
    .i_hazard_ctrl_load_ex      (load_ex),
    .i_hazard_ctrl_fwd_rd       (fwd_rd),
    .i_hazard_ctrl_fwd_we       (fwd_we),
    .i_hazard_ctrl_lat_issue    (lat_issue),
    .i_hazard_ctrl_lat_done     (lat_done),
    .i_hazard_ctrl_lat_done_rd  (lat_done_rd),
    .i_hazard_ctrl_pcsrc_ex     (pcsrc),
    .i_hazard_ctrl_icache_stall (icache),
    .i_hazard_ctrl_dcache_stall (dcache),
    .i_hazard_ctrl_csr_flush    (csr),
    .o_hazard_ctrl_fwda_ex      (fwda),
    .o_hazard_ctrl_fwdb_ex      (fwdb),
    .o_hazard_ctrl_stall        (stall),
    .o_hazard_ctrl_flush        (flush),
    .o_hazard_ctrl_pend_cnt     (pend_cnt),
    .o_hazard_ctrl_timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    rs1_id = '0; rs2_id = '0; rd_id = '0;
    rs1_ex = '0; rs2_ex = '0; rd_ex = '0;
    load_ex = 1'b0; fwd_rd = '0; fwd_we = '0;
    lat_issue = 1'b0; lat_done = 1'b0;
    lat_done_rd = '0; pcsrc = 1'b0;
    icache = 1'b0; dcache = 1'b0; csr = '0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_fwda", 32'(fwda), 32'h0);
    chk("rst_fwdb", 32'(fwdb), 32'h0);
    chk("rst_cnt", 32'(pend_cnt), 32'h0);
    chk("rst_to", 32'(timeout), 32'h0);

    // forwarding priority
    fwd_rd = {5'd5, 5'd5};
    fwd_we = 2'b11;
    rs1_ex = 5'd5;
    rs2_ex = 5'd6;
    #1;
    chk("fwda_young", 32'(fwda), 32'd1);
    chk("fwdb_nomatch", 32'(fwdb), 32'd0);
    fwd_we = 2'b10;
    #1;
    chk("fwda_old", 32'(fwda), 32'd2);
    fwd_rd = {5'd6, 5'd0};
    fwd_we = 2'b11;
    rs1_ex = 5'd0;
    #1;
    chk("fwda_x0", 32'(fwda), 32'd0);
    chk("fwdb_old", 32'(fwdb), 32'd2);
    fwd_rd = '0; fwd_we = '0;
    rs1_ex = '0; rs2_ex = '0;

    // load-use
    load_ex = 1'b1;
    rd_ex = 5'd7;
    rs2_id = 5'd7;
    #1;
    chk("lu_stall", 32'(stall), 32'b00011);
    chk("lu_flush", 32'(flush), 32'b0010);
    step();
    load_ex = 1'b0;
    #1;
    chk("lu_stall_off", 32'(stall), 32'h0);
    chk("lu_flush_off", 32'(flush), 32'h0);
    rd_ex = '0; rs2_id = '0;
    rd_ex = 5'd0; load_ex = 1'b1; rs1_id = 5'd0;
    #1;
    chk("lu_x0", 32'(stall), 32'h0);
    load_ex = 1'b0;

    // branch redirect
    pcsrc = 1'b1;
    #1;
    chk("pcsrc_flush", 32'(flush), 32'b0011);
    pcsrc = 1'b0;

    // RAW on long-latency result
    lat_issue = 1'b1;
    rd_id = 5'd9;
    #1;
    chk("iss9_stall", 32'(stall), 32'h0);
    step();
    lat_issue = 1'b0;
    rd_id = '0;
    rs1_id = 5'd9;
    #1;
    chk("raw_cnt1", 32'(pend_cnt), 32'd1);
    chk("raw_stall", 32'(stall), 32'b00011);
    chk("raw_flush", 32'(flush), 32'b0010);
    step();
    chk("raw_stall2", 32'(stall), 32'b00011);
    lat_done = 1'b1;
    lat_done_rd = 5'd9;
    #1;
    chk("raw_done_cyc", 32'(stall), 32'b00011);
    step();
    lat_done = 1'b0;
    #1;
    chk("raw_cnt0", 32'(pend_cnt), 32'd0);
    chk("raw_release", 32'(stall), 32'h0);
    rs1_id = '0;

    // fill scoreboard
    for (int k = 1; k <= 4; k++) begin
      lat_issue = 1'b1;
      rd_id = 5'(k);
      #1;
      chk("fill_stall", 32'(stall), 32'h0);
      step();
    end
    rd_id = 5'd5;
    #1;
    chk("full_cnt", 32'(pend_cnt), 32'd4);
    chk("full_stall", 32'(stall), 32'b00011);
    step();
    chk("full_reject", 32'(pend_cnt), 32'd4);
    lat_issue = 1'b0;
    lat_done = 1'b1;
    lat_done_rd = 5'd2;
    step();
    chk("done2_cnt", 32'(pend_cnt), 32'd3);
    lat_issue = 1'b1;
    rd_id = 5'd6;
    lat_done_rd = 5'd1;
    #1;
    chk("swap_stall", 32'(stall), 32'h0);
    step();
    lat_issue = 1'b0;
    lat_done = 1'b0;
    rd_id = '0;
    #1;
    chk("swap_cnt", 32'(pend_cnt), 32'd3);
    rs1_id = 5'd6;
    #1;
    chk("x6_pend", 32'(stall), 32'b00011);
    rs1_id = 5'd1;
    #1;
    chk("x1_free", 32'(stall), 32'h0);
    rs1_id = '0;
    lat_issue = 1'b1;
    rd_id = 5'd4;
    #1;
    chk("waw_stall", 32'(stall), 32'b00011);
    lat_issue = 1'b0;
    rd_id = '0;
    lat_done = 1'b1;
    lat_done_rd = 5'd1;
    step();
    lat_done = 1'b0;
    #1;
    chk("done_nonpend", 32'(pend_cnt), 32'd3);

    // reset mid-operation
    rs2_id = 5'd3;
    #1;
    chk("pre_rst_raw", 32'(stall), 32'b00011);
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", 32'(pend_cnt), 32'd0);
    chk("arst_stall", 32'(stall), 32'h0);
    step();
    rst_n = 1'b1;
    rs2_id = '0;

    // flush holdover under dcache stall
    dcache = 1'b1;
    csr = 4'b0100;
    #1;
    chk("dc_stall", 32'(stall), 32'b01111);
    chk("dc_fl1", 32'(flush), 32'h0);
    step();
    csr = '0;
    #1;
    chk("dc_fl2", 32'(flush), 32'h0);
    step();
    chk("dc_fl3", 32'(flush), 32'h0);
    step();
    dcache = 1'b0;
    #1;
    chk("dc_release", 32'(flush), 32'b0100);
    step();
    chk("dc_once", 32'(flush), 32'h0);

    // watchdog
    icache = 1'b1;
    #1;
    chk("ic_stall", 32'(stall), 32'b00001);
    repeat (1023) step();
    chk("wd_pre", 32'(timeout), 32'd0);
    step();
    chk("wd_hit", 32'(timeout), 32'd1);
    icache = 1'b0;
    step();
    chk("wd_sticky", 32'(timeout), 32'd1);
    step();
    chk("wd_sticky2", 32'(timeout), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("wd_rst", 32'(timeout), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
